regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter for the integer register file. Two writeback sources share the register file's single write port: port A is the in-order pipeline writeback and port B is the long-latency load/multi-cycle unit. Each source has its own 2-entry FIFO, and a round-robin arbiter drains the FIFOs into a registered write port. A combinational busy query lets decode stall on registers that still have writes pending in the FIFOs.

## Interface
- `DATA_W`, 32, register data width.
- `ADDR_W`, 5, register address width (32 registers).
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `a_valid` in 1: port A write request.
- `a_ready` out 1: port A can accept a request.
- `a_addr` in `ADDR_W`: port A destination register.
- `a_data` in `DATA_W`: port A write data.
- `b_valid` / `b_ready` / `b_addr` / `b_data`: port B, same meanings as port A.
- `q_addr` in `ADDR_W`: register address for the busy query.
- `q_busy` out 1: a write to `q_addr` is still queued.
- `rf_we` out 1: register file write enable.
- `rf_waddr` out `ADDR_W`: register file write address.
- `rf_wdata` out `DATA_W`: register file write data.

## Operation
**Handshake**
- A transfer on a port occurs on a rising edge where `x_valid` and `x_ready` are both 1.
- `x_ready` is 1 when that port's FIFO count is below 2. It does not depend on a pop in the same cycle. It is 0 while `rst` is low.
- Transfers with `x_addr` = 0 are accepted and discarded. They are never enqueued and never reach `rf_we`.

**FIFOs**
- Each port has a 2-entry FIFO holding {addr, data} and a count of 0..2.
- Order within a port is preserved. A push and a pop in the same cycle leave the count unchanged.

**Arbitration** (combinational, on the FIFO heads)
- If only one FIFO is non-empty, that FIFO wins.
- If both are non-empty, the port not granted last wins.
- The `last` pointer updates only on a grant. After reset, `last` = A, so B wins the first tie.

**Output register**
- On every edge, `rf_we` takes the value "a grant exists".
- On a grant, `rf_waddr` and `rf_wdata` load the winning head and that FIFO pops.
- When there is no grant, `rf_waddr` and `rf_wdata` hold their values.
- At most one write is issued per cycle.

**Busy query**
- `q_busy` = (`q_addr` != 0) AND (any valid entry in either FIFO has addr == `q_addr`).
- The output-register stage is excluded, because the register file bypasses `wdata` to readers in the write cycle.

**Cross-port ordering**
- Ordering between ports is not guaranteed.
- Issue logic uses `q_busy` to prevent outstanding writes to the same register on both ports.

**Reset**
- All of the following return to reset values immediately whenever `rst` goes low, including mid-operation:
  - FIFO counts and contents are discarded.
  - `last` = A.
  - `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0.
  - `q_busy` = 0.
- No partially issued write is completed.

## Timing
- **Latency:** a request accepted at edge E0 with empty FIFOs and no contention drives `rf_we` = 1 in the cycle after edge E1. That is two edges from acceptance to the write-enable cycle; the register file commits at the following edge.
- **Single-port throughput:** one write per cycle with `x_ready` held at 1. The count steady-states at 1 because push and pop happen together.
- **Both ports saturated:** the grants alternate A/B/A/B. Each port is served at 1/2 rate, and each ready deasserts once its count reaches 2.
- **`q_busy`:** combinational from `q_addr` and FIFO state. It rises in the cycle after the accepting edge and falls in the cycle after the popping edge.
- **Starvation:** a non-empty FIFO is granted within 2 cycles.

## Test plan
1. **Reset values.** Assert `rst` low for 3 cycles, then release. Required: `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `a_ready` = `b_ready` = 1, `q_busy` = 0.
2. **Single write and busy window.** Send A: addr 5, data 0xDEADBEEF at E0.
   - `q_addr` = 5 reads `q_busy` = 1 during the E0..E1 cycle.
   - `rf_we` = 1, `rf_waddr` = 5, `rf_wdata` = 0xDEADBEEF during the E1..E2 cycle.
   - `rf_we` = 0 after E2.
3. **Simultaneous requests.** At the same edge, send A (addr 1, data 0x11) and B (addr 2, data 0x22). Required: B is written first, then A the next cycle.
4. **Saturation.** Hold both ports valid for 10 cycles with incrementing addresses 1..10. Required:
   - The writes strictly alternate between ports.
   - Each ready drops to 0 once its FIFO holds 2 entries.
   - No request is lost, and each port's order is preserved.
5. **x0 discard.** Send A with addr 0, data 0xFFFFFFFF. Required: accepted with `a_ready` = 1, `rf_we` stays 0, `q_busy` stays 0 for `q_addr` = 0.
6. **Reset mid-operation.** Fill both FIFOs (4 entries), then pulse `rst` low mid-cycle. Required: `rf_we` = 0 immediately, no further writes after release, `q_busy` = 0 for all addresses.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the integer register file. Two writeback sources
// (A: in-order pipeline, B: long-latency unit) each feed a 2-entry FIFO; a
// round-robin arbiter drains the FIFO heads into a registered write port.
// A combinational busy query reports registers with writes still queued.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    // Index 0 is port A, index 1 is port B. Slot 0 is always the FIFO head.
    logic [ADDR_W-1:0] fifo_addr_q [2][2];
    logic [ADDR_W-1:0] fifo_addr_d [2][2];
    logic [DATA_W-1:0] fifo_data_q [2][2];
    logic [DATA_W-1:0] fifo_data_d [2][2];
    logic [1:0]        cnt_q [2];
    logic [1:0]        cnt_d [2];
    logic              last_q, last_d;  // 1: B was granted last
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_addr [2];
    logic [DATA_W-1:0] in_data [2];
    logic [1:0]        ready;
    logic [1:0]        push;
    logic [1:0]        non_empty;
    logic [1:0]        grant;
    logic [1:0]        slot;

    // Handshake: ready ignores same-cycle pops; x0 writes are accepted but dropped
    always_comb begin
        in_valid   = {b_valid, a_valid};
        in_addr[0] = a_addr;
        in_addr[1] = b_addr;
        in_data[0] = a_data;
        in_data[1] = b_data;
        ready      = 2'b00;
        push       = 2'b00;
        non_empty  = 2'b00;
        for (int p = 0; p < 2; p++) begin
            ready[p]     = rst && (cnt_q[p] != 2'd2);
            push[p]      = in_valid[p] && ready[p] && (in_addr[p] != '0);
            non_empty[p] = (cnt_q[p] != 2'd0);
        end
    end

    assign a_ready = ready[0];
    assign b_ready = ready[1];

    // Round-robin grant: a lone non-empty FIFO wins, ties go to the port not served last
    always_comb begin
        grant    = 2'b00;
        grant[0] = non_empty[0] && (!non_empty[1] || last_q);
        grant[1] = non_empty[1] && (!non_empty[0] || !last_q);
    end

    // FIFO next state: pop shifts slot 1 into the head, push lands after the survivors
    always_comb begin
        slot = 2'b00;
        for (int p = 0; p < 2; p++) begin
            fifo_addr_d[p][0] = fifo_addr_q[p][0];
            fifo_addr_d[p][1] = fifo_addr_q[p][1];
            fifo_data_d[p][0] = fifo_data_q[p][0];
            fifo_data_d[p][1] = fifo_data_q[p][1];
            slot[p] = (cnt_q[p] == 2'd2) || ((cnt_q[p] == 2'd1) && !grant[p]);
            if (grant[p]) begin
                fifo_addr_d[p][0] = fifo_addr_q[p][1];
                fifo_data_d[p][0] = fifo_data_q[p][1];
            end
            if (push[p]) begin
                fifo_addr_d[p][slot[p]] = in_addr[p];
                fifo_data_d[p][slot[p]] = in_data[p];
            end
            cnt_d[p] = cnt_q[p] + {1'b0, push[p]} - {1'b0, grant[p]};
        end
    end

    // Output stage and round-robin pointer next state; address/data hold without a grant
    always_comb begin
        last_d     = last_q;
        rf_we_d    = |grant;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant[1]) begin
            last_d     = 1'b1;
            rf_waddr_d = fifo_addr_q[1][0];
            rf_wdata_d = fifo_data_q[1][0];
        end else if (grant[0]) begin
            last_d     = 1'b0;
            rf_waddr_d = fifo_addr_q[0][0];
            rf_wdata_d = fifo_data_q[0][0];
        end
    end

    // State registers; reset discards queued writes and any write in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                cnt_q[p] <= 2'd0;
                for (int s = 0; s < 2; s++) begin
                    fifo_addr_q[p][s] <= '0;
                    fifo_data_q[p][s] <= '0;
                end
            end
            last_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                cnt_q[p] <= cnt_d[p];
                for (int s = 0; s < 2; s++) begin
                    fifo_addr_q[p][s] <= fifo_addr_d[p][s];
                    fifo_data_q[p][s] <= fifo_data_d[p][s];
                end
            end
            last_q     <= last_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // Busy query over queued entries only; the output stage is covered by RF bypass
    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if ((cnt_q[p] != 2'd0) && (fifo_addr_q[p][0] == q_addr)) hit = 1'b1;
            if ((cnt_q[p] == 2'd2) && (fifo_addr_q[p][1] == q_addr)) hit = 1'b1;
        end
        q_busy = hit && (q_addr != '0);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a directed vector table for
// single writes, tie-breaking and x0 discard, plus hand-written sequences
// for saturation and reset in mid-operation.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr = '0, b_addr = '0, q_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        q_busy, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int passed = 0;
    int total  = 0;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .q_addr  (q_addr),
        .q_busy  (q_busy),
        .rf_we   (rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic [4:0]  qa;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ar;
        logic        br;
        logic        busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic [4:0] qa, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic ar, input logic br,
                                input logic busy);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd; v.qa = qa;
        v.we = we; v.wa = wa; v.wd = wd; v.ar = ar; v.br = br; v.busy = busy;
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs [13];
        int   busy_hits;
        int   a_sent, b_sent, a_wr, b_wr, prev, cyc, port;
        bit   a_blk, b_blk;

        // Inputs applied after a falling edge, outputs sampled 1 time unit before the rising edge.
        vecs[0]  = mk(0, 0, 0,             0, 0, 0,     0, 0, 0, 32'h0,        1, 1, 0);
        vecs[1]  = mk(1, 5, 32'hDEADBEEF,  0, 0, 0,     5, 0, 0, 32'h0,        1, 1, 0);
        vecs[2]  = mk(0, 0, 0,             0, 0, 0,     5, 0, 0, 32'h0,        1, 1, 1);
        vecs[3]  = mk(0, 0, 0,             0, 0, 0,     5, 1, 5, 32'hDEADBEEF, 1, 1, 0);
        vecs[4]  = mk(0, 0, 0,             0, 0, 0,     5, 0, 5, 32'hDEADBEEF, 1, 1, 0);
        vecs[5]  = mk(1, 1, 32'h11,        1, 2, 32'h22, 1, 0, 5, 32'hDEADBEEF, 1, 1, 0);
        vecs[6]  = mk(0, 0, 0,             0, 0, 0,     2, 0, 5, 32'hDEADBEEF, 1, 1, 1);
        vecs[7]  = mk(0, 0, 0,             0, 0, 0,     1, 1, 2, 32'h22,       1, 1, 1);
        vecs[8]  = mk(0, 0, 0,             0, 0, 0,     1, 1, 1, 32'h11,       1, 1, 0);
        vecs[9]  = mk(0, 0, 0,             0, 0, 0,     1, 0, 1, 32'h11,       1, 1, 0);
        vecs[10] = mk(1, 0, 32'hFFFFFFFF,  0, 0, 0,     0, 0, 1, 32'h11,       1, 1, 0);
        vecs[11] = mk(0, 0, 0,             0, 0, 0,     0, 0, 1, 32'h11,       1, 1, 0);
        vecs[12] = mk(0, 0, 0,             0, 0, 0,     0, 0, 1, 32'h11,       1, 1, 0);

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        #4;
        chk("reset_a_ready_low", {31'b0, a_ready}, 32'd0);
        chk("reset_b_ready_low", {31'b0, b_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
            q_addr  = vecs[i].qa;
            #4;
            chk($sformatf("v%0d_rf_we", i),    {31'b0, rf_we},   {31'b0, vecs[i].we});
            chk($sformatf("v%0d_rf_waddr", i), {27'b0, rf_waddr}, {27'b0, vecs[i].wa});
            chk($sformatf("v%0d_rf_wdata", i), rf_wdata,          vecs[i].wd);
            chk($sformatf("v%0d_a_ready", i),  {31'b0, a_ready}, {31'b0, vecs[i].ar});
            chk($sformatf("v%0d_b_ready", i),  {31'b0, b_ready}, {31'b0, vecs[i].br});
            chk($sformatf("v%0d_q_busy", i),   {31'b0, q_busy},  {31'b0, vecs[i].busy});
        end

        // Saturation: both ports stream addresses 1..10, data tagged by port in the top nibble
        a_sent = 0; b_sent = 0; a_wr = 0; b_wr = 0; prev = -1; cyc = 0;
        a_blk = 0; b_blk = 0;
        while ((a_wr < 10 || b_wr < 10) && cyc < 80) begin
            @(negedge clk);
            a_valid = (a_sent < 10);
            a_addr  = 5'(a_sent + 1);
            a_data  = 32'hA000_0000 | 32'(a_sent + 1);
            b_valid = (b_sent < 10);
            b_addr  = 5'(b_sent + 1);
            b_data  = 32'hB000_0000 | 32'(b_sent + 1);
            q_addr  = '0;
            #4;
            if (rf_we) begin
                port = (rf_wdata[31:28] == 4'hB) ? 1 : 0;
                if (port == 0) begin
                    chk("sat_a_addr", {27'b0, rf_waddr}, 32'(a_wr + 1));
                    chk("sat_a_data", rf_wdata, 32'hA000_0000 | 32'(a_wr + 1));
                    a_wr++;
                end else begin
                    chk("sat_b_addr", {27'b0, rf_waddr}, 32'(b_wr + 1));
                    chk("sat_b_data", rf_wdata, 32'hB000_0000 | 32'(b_wr + 1));
                    b_wr++;
                end
                if (prev >= 0) chk("sat_alternate", 32'(port), 32'(1 - prev));
                prev = port;
            end
            if (!a_ready) a_blk = 1;
            if (!b_ready) b_blk = 1;
            if (a_valid && a_ready) a_sent++;
            if (b_valid && b_ready) b_sent++;
            cyc++;
        end
        chk("sat_a_all_written", 32'(a_wr), 32'd10);
        chk("sat_b_all_written", 32'(b_wr), 32'd10);
        chk("sat_a_ready_dropped", {31'b0, a_blk}, 32'd1);
        chk("sat_b_ready_dropped", {31'b0, b_blk}, 32'd1);

        // Reset mid-operation with both FIFOs loaded
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7777_7777;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h9999_9999;
        repeat (3) @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        q_addr = 5'd7;
        #2;
        chk("pre_reset_busy7", {31'b0, q_busy}, 32'd1);
        chk("pre_reset_rf_we", {31'b0, rf_we}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset_rf_we", {31'b0, rf_we}, 32'd0);
        chk("midreset_rf_waddr", {27'b0, rf_waddr}, 32'd0);
        chk("midreset_rf_wdata", rf_wdata, 32'd0);
        chk("midreset_busy7", {31'b0, q_busy}, 32'd0);
        chk("midreset_a_ready", {31'b0, a_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #4;
            chk($sformatf("post_reset_rf_we_%0d", i), {31'b0, rf_we}, 32'd0);
        end
        busy_hits = 0;
        for (int a = 0; a < 32; a++) begin
            q_addr = 5'(a);
            #0.1;
            if (q_busy) busy_hits++;
        end
        chk("post_reset_busy_any", 32'(busy_hits), 32'd0);
        chk("post_reset_a_ready", {31'b0, a_ready}, 32'd1);
        chk("post_reset_b_ready", {31'b0, b_ready}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
